syn_fft_bfly_sched: RTL and testbench

- Sequences an in-place, iterative radix-2 DIT FFT over the shared sample RAM.
- Walks every stage and every butterfly. For each butterfly it issues the upper/lower RAM addresses and the twiddle ROM index to the butterfly datapath (complex mul + add/sub).
- Counts write-back acknowledgements so that a stage never starts before the previous stage's results are in RAM.
- Sits between the FFT top-level control (start/done) and the butterfly datapath.

---
 rtl/syn_fft_bfly_sched.sv | 207 ++++++++++++++++++++
 tb/tb_syn_fft_bfly_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_fft_bfly_sched.sv
// Butterfly scheduler for an in-place iterative radix-2 DIT FFT.
// Walks every stage/butterfly, issues RAM addresses and twiddle index to the
// datapath, and throttles on outstanding write-back acknowledgements.
// Optional build macro: SYN_FFT_SCHED_PERF_EN adds stall_cnt_o / run_cnt_o.
module syn_fft_bfly_sched #(
    parameter int unsigned P_N_LOG2       = 7,
    parameter int unsigned P_MAX_INFLIGHT = 4
) (
    input  logic                  clk_ir,
    input  logic                  rst_il,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  bfly_vld_o,
    input  logic                  bfly_rdy_i,
    output logic [P_N_LOG2-1:0]   bfly_addr_a_o,
    output logic [P_N_LOG2-1:0]   bfly_addr_b_o,
    output logic [P_N_LOG2-2:0]   bfly_twdl_idx_o,
    input  logic                  wb_ack_i,
    output logic [3:0]            stage_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ack_err_o
`ifdef SYN_FFT_SCHED_PERF_EN
    ,
    output logic [15:0]           stall_cnt_o,
    output logic [15:0]           run_cnt_o
`endif
);

    localparam int unsigned AW = P_N_LOG2;
    localparam int unsigned JW = P_N_LOG2 - 1;
    localparam int unsigned IW = $clog2(P_MAX_INFLIGHT + 1);

    localparam logic [JW-1:0] J_LAST  = {JW{1'b1}};
    localparam logic [3:0]    S_LAST  = 4'(P_N_LOG2 - 1);
    localparam logic [IW-1:0] INF_MAX = IW'(P_MAX_INFLIGHT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [JW-1:0] j_q, j_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [JW-1:0] twdl_q, twdl_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          issue;
    logic [AW-1:0] half, k, grp;

`ifdef SYN_FFT_SCHED_PERF_EN
    logic [15:0]   stall_q, stall_d;
    logic [15:0]   run_q, run_d;
`endif

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        inflight_d = inflight_q;
        ack_err_d  = ack_err_q;
        issue      = vld_q & bfly_rdy_i;

        if (issue && !wb_ack_i) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!issue && wb_ack_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_ISSUE;
                    s_d       = '0;
                    j_d       = '0;
                    ack_err_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_d == '0) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An ack with nothing outstanding is flagged, including late acks after abort
        if (!issue && wb_ack_i && (inflight_q == '0)) begin
            ack_err_d = 1'b1;
        end

        if (abort_i) begin
            state_d    = ST_IDLE;
            s_d        = '0;
            j_d        = '0;
            inflight_d = '0;
        end

        // Request is offered only while below the in-flight limit; since in-flight
        // cannot rise without a handshake, a raised request stays up until taken.
        vld_d = (state_d == ST_ISSUE) && (inflight_d < INF_MAX);

        half     = AW'(1) << s_d;
        k        = AW'(j_d) & (half - AW'(1));
        grp      = AW'(j_d) >> s_d;
        addr_a_d = (grp << (s_d + 4'd1)) | k;
        addr_b_d = addr_a_d | half;
        twdl_d   = JW'(k << (4'(JW) - s_d));

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

`ifdef SYN_FFT_SCHED_PERF_EN
        stall_d = stall_q;
        run_d   = run_q;
        if ((state_q == ST_ISSUE) && !issue && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (busy_q && (run_q != 16'hFFFF)) begin
            run_d = run_q + 16'd1;
        end
        if ((state_q == ST_IDLE) && start_i) begin
            stall_d = '0;
            run_d   = '0;
        end
`endif
    end

    // State, counters and output registers
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            inflight_q <= '0;
            vld_q      <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            twdl_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            twdl_q     <= twdl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

`ifdef SYN_FFT_SCHED_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            stall_q <= '0;
            run_q   <= '0;
        end else begin
            stall_q <= stall_d;
            run_q   <= run_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign run_cnt_o   = run_q;
`endif

    assign bfly_vld_o      = vld_q;
    assign bfly_addr_a_o   = addr_a_q;
    assign bfly_addr_b_o   = addr_b_q;
    assign bfly_twdl_idx_o = twdl_q;
    assign stage_o         = s_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign ack_err_o       = ack_err_q;

endmodule

// File: tb/tb_syn_fft_bfly_sched.sv
// Directed bench for syn_fft_bfly_sched with N=8 and an in-flight limit of 2.
`timescale 1ns/1ps
module tb_syn_fft_bfly_sched;

    localparam int unsigned LG   = 3;
    localparam int unsigned MAXI = 2;
    localparam int unsigned NB   = 12;

    logic       clk_ir = 1'b0;
    logic       rst_il, start_i, abort_i, bfly_rdy_i, wb_ack_i;
    logic       bfly_vld_o;
    logic [2:0] bfly_addr_a_o, bfly_addr_b_o;
    logic [1:0] bfly_twdl_idx_o;
    logic [3:0] stage_o;
    logic       busy_o, done_o, ack_err_o;
`ifdef SYN_FFT_SCHED_PERF_EN
    logic [15:0] stall_cnt_o, run_cnt_o;
`endif

    typedef struct packed {
        logic [3:0] s;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } bfly_t;

    bfly_t      exp_tab [NB];
    bfly_t      cap [32];
    int         ncap, errors, checks, cyc;
    int         done_cnt, busy_cyc, ack_dly, last_ack_cyc, done_cyc, vld_hi;
    int         ack_due[$];
    logic [3:0] prev_stage;
    logic       hold_v;
    logic [7:0] hold_req;

    syn_fft_bfly_sched #(.P_N_LOG2(LG), .P_MAX_INFLIGHT(MAXI)) dut (
        .clk_ir          (clk_ir),
        .rst_il          (rst_il),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .bfly_vld_o      (bfly_vld_o),
        .bfly_rdy_i      (bfly_rdy_i),
        .bfly_addr_a_o   (bfly_addr_a_o),
        .bfly_addr_b_o   (bfly_addr_b_o),
        .bfly_twdl_idx_o (bfly_twdl_idx_o),
        .wb_ack_i        (wb_ack_i),
        .stage_o         (stage_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ack_err_o       (ack_err_o)
`ifdef SYN_FFT_SCHED_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt_o),
        .run_cnt_o       (run_cnt_o)
`endif
    );

    always #5 clk_ir = ~clk_ir;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock cycle: drive rdy/ack for this cycle, record what the datapath sees
    task automatic cyc_step(input logic rdy, input logic ack);
        if (hold_v) begin
            check("stall_vld_held", int'(bfly_vld_o), 1);
            check("stall_req_held",
                  int'({bfly_addr_a_o, bfly_addr_b_o, bfly_twdl_idx_o}), int'(hold_req));
        end
        if (busy_o && (stage_o != prev_stage)) begin
            check("drain_before_stage", ack_due.size(), 0);
        end
        prev_stage = stage_o;
        bfly_rdy_i = rdy;
        wb_ack_i   = ack;
        if (bfly_vld_o && rdy) begin
            if (ncap < 32) cap[ncap] = {stage_o, bfly_addr_a_o, bfly_addr_b_o, bfly_twdl_idx_o};
            ncap++;
            ack_due.push_back(cyc + ack_dly);
        end
        if (ack) begin
            last_ack_cyc = cyc;
            if (ack_due.size() > 0) void'(ack_due.pop_front());
        end
        if (busy_o) busy_cyc++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hold_v   = bfly_vld_o && !rdy && !abort_i;
        hold_req = {bfly_addr_a_o, bfly_addr_b_o, bfly_twdl_idx_o};
        @(posedge clk_ir);
        #1;
        cyc++;
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic tick(input int rdy_pct, input bit ack_en);
        logic r, a;
        r = ($urandom_range(99) < rdy_pct);
        a = 1'b0;
        if (ack_en && (ack_due.size() > 0) && (ack_due[0] <= cyc)) a = 1'b1;
        cyc_step(r, a);
    endtask

    task automatic new_run();
        ncap     = 0;
        done_cnt = 0;
        busy_cyc = 0;
        hold_v   = 1'b0;
        ack_due.delete();
        for (int i = 0; i < 32; i++) cap[i] = '1;
    endtask

    task automatic run_to_done(input int rdy_pct, input int budget);
        for (int i = 0; (i < budget) && !done_o; i++) tick(rdy_pct, 1'b1);
        check("done_reached", int'(done_o), 1);
        tick(rdy_pct, 1'b1);
        check("done_one_cycle", int'(done_o), 0);
        check("busy_falls", int'(busy_o), 0);
    endtask

    task automatic cmp_seq(input string tag);
        check({tag, "_count"}, ncap, NB);
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (cap[i] !== exp_tab[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got s=%0d a=%0d b=%0d tw=%0d, expected s=%0d a=%0d b=%0d tw=%0d",
                         tag, i, cap[i].s, cap[i].a, cap[i].b, cap[i].tw,
                         exp_tab[i].s, exp_tab[i].a, exp_tab[i].b, exp_tab[i].tw);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vld"},   int'(bfly_vld_o), 0);
        check({tag, "_busy"},  int'(busy_o), 0);
        check({tag, "_done"},  int'(done_o), 0);
        check({tag, "_err"},   int'(ack_err_o), 0);
        check({tag, "_stage"}, int'(stage_o), 0);
        check({tag, "_addr"},  int'({bfly_addr_a_o, bfly_addr_b_o, bfly_twdl_idx_o}), 0);
`ifdef SYN_FFT_SCHED_PERF_EN
        check({tag, "_perf"},  int'({stall_cnt_o, run_cnt_o}), 0);
`endif
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; ack_dly = 1; ncap = 0;
        done_cnt = 0; busy_cyc = 0; last_ack_cyc = 0; done_cyc = 0; vld_hi = 0;
        prev_stage = '0; hold_v = 1'b0; hold_req = '0;
        rst_il = 1'b0; start_i = 1'b0; abort_i = 1'b0; bfly_rdy_i = 1'b0; wb_ack_i = 1'b0;

        exp_tab[0]  = '{4'd0, 3'd0, 3'd1, 2'd0};
        exp_tab[1]  = '{4'd0, 3'd2, 3'd3, 2'd0};
        exp_tab[2]  = '{4'd0, 3'd4, 3'd5, 2'd0};
        exp_tab[3]  = '{4'd0, 3'd6, 3'd7, 2'd0};
        exp_tab[4]  = '{4'd1, 3'd0, 3'd2, 2'd0};
        exp_tab[5]  = '{4'd1, 3'd1, 3'd3, 2'd2};
        exp_tab[6]  = '{4'd1, 3'd4, 3'd6, 2'd0};
        exp_tab[7]  = '{4'd1, 3'd5, 3'd7, 2'd2};
        exp_tab[8]  = '{4'd2, 3'd0, 3'd4, 2'd0};
        exp_tab[9]  = '{4'd2, 3'd1, 3'd5, 2'd1};
        exp_tab[10] = '{4'd2, 3'd2, 3'd6, 2'd2};
        exp_tab[11] = '{4'd2, 3'd3, 3'd7, 2'd3};

        repeat (3) @(posedge clk_ir);
        #1;
        check_idle_outputs("reset");
        rst_il = 1'b1;
        cyc_step(1'b0, 1'b0);

        // Full-rate run, ack one cycle after each issue
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        check("start_to_vld", int'(bfly_vld_o), 1);
        check("busy_after_start", int'(busy_o), 1);
        check("first_addr_b", int'(bfly_addr_b_o), 1);
        run_to_done(100, 200);
        cmp_seq("seq_rdy1");
        check("done_pulses", done_cnt, 1);
        check("ack_to_done", done_cyc - last_ack_cyc, 1);
        check("stage_hold_idle", int'(stage_o), 2);
        check("no_ack_err", int'(ack_err_o), 0);
`ifdef SYN_FFT_SCHED_PERF_EN
        check("perf_stall_rdy1", int'(stall_cnt_o), 0);
        check("perf_run_rdy1", int'(run_cnt_o), busy_cyc);
`endif

        // Random backpressure
        new_run();
        start_i = 1'b1;
        cyc_step(1'b0, 1'b0);
        run_to_done(50, 400);
        cmp_seq("seq_backpressure");
        check("done_pulses_bp", done_cnt, 1);
        check("ack_to_done_bp", done_cyc - last_ack_cyc, 1);

        // Acks withheld: only the in-flight limit of requests may go out
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        vld_hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bfly_vld_o) vld_hi++;
            tick(100, 1'b0);
        end
        check("held_handshakes", ncap, 2);
        check("held_vld_cycles", vld_hi, 2);
        check("held_vld_low", int'(bfly_vld_o), 0);
        check("held_stage", int'(stage_o), 0);
        run_to_done(100, 300);
        cmp_seq("seq_held_acks");

        // Same-cycle issue and ack, in-flight limit, ignored mid-run start
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        check("lim_vld_a", int'(bfly_vld_o), 1);
        cyc_step(1'b1, 1'b0);
        check("lim_vld_b", int'(bfly_vld_o), 1);
        cyc_step(1'b1, 1'b1);
        check("vld_after_hs_ack", int'(bfly_vld_o), 1);
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        check("vld_at_limit", int'(bfly_vld_o), 0);
        check("stage_midrun_start", int'(stage_o), 0);
        check("busy_midrun_start", int'(busy_o), 1);
        cyc_step(1'b1, 1'b1);
        check("vld_after_ack", int'(bfly_vld_o), 1);
        check("addr_a_j3", int'(bfly_addr_a_o), 6);
        run_to_done(100, 200);
        cmp_seq("seq_limit");
        check("done_pulses_lim", done_cnt, 1);
        check("no_ack_err_lim", int'(ack_err_o), 0);

        // Abort during stage 1, then a late ack
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        for (int i = 0; (i < 50) && !(stage_o == 4'd1 && bfly_vld_o); i++) tick(100, 1'b1);
        tick(100, 1'b1);
        check("abort_pre_stage", int'(stage_o), 1);
        abort_i = 1'b1;
        cyc_step(1'b0, 1'b0);
        check("abort_vld", int'(bfly_vld_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_stage", int'(stage_o), 0);
        cyc_step(1'b0, 1'b1);
        check("late_ack_err", int'(ack_err_o), 1);
        repeat (3) cyc_step(1'b0, 1'b0);
        check("abort_no_done", done_cnt, 0);
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        check("err_clr_on_start", int'(ack_err_o), 0);
        run_to_done(100, 200);
        cmp_seq("seq_after_abort");

        // Async reset in the middle of stage 1
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        repeat (8) tick(100, 1'b1);
        check("pre_reset_stage", int'(stage_o), 1);
        rst_il = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk_ir);
        #1;
        rst_il = 1'b1;
        new_run();
        cyc_step(1'b0, 1'b0);
        check("post_reset_busy", int'(busy_o), 0);

`ifdef SYN_FFT_SCHED_PERF_EN
        // First request held off for five cycles
        new_run();
        start_i = 1'b1;
        cyc_step(1'b1, 1'b0);
        repeat (5) cyc_step(1'b0, 1'b0);
        run_to_done(100, 200);
        cmp_seq("seq_perf");
        check("perf_stall_5", int'(stall_cnt_o), 5);
        check("perf_run", int'(run_cnt_o), busy_cyc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
